draw_rect_rom: RTL and testbench

Pixel-stream consumer of the rectangle position produced by `draw_rect_ctl`. It sits in the VGA pipeline after the background stage and overlays a ROM-stored image at `(xpos, ypos)` onto the incoming timing/RGB stream. The position is latched once per frame so the image never tears. All timing signals are passed through with matched latency.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/image_rom.sv | 21 ++
 rtl/draw_rect_rom.sv | 117 +++++++++++
 tb/tb_draw_rect_rom.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pipeline types and constants: screen geometry, colour width,
// overlay key colour and the timing bundle carried through stage registers.
package vga_pkg;

    localparam int HOR_PIXELS = 1024;
    localparam int VER_PIXELS = 768;
    localparam int RGB_W      = 12;

    localparam logic [RGB_W-1:0] TRANSPARENT_KEY = 12'hF0F;

    typedef struct packed {
        logic [10:0] hcount;
        logic [10:0] vcount;
        logic        hsync;
        logic        vsync;
        logic        hblnk;
        logic        vblnk;
    } vga_tim_t;

endpackage

// File: rtl/image_rom.sv
// 4096x12 image ROM with a 1-cycle registered read.
// Addressed as {dy[5:0], dx[5:0]} by draw_rect_rom.
module image_rom #(
    parameter string INIT_FILE = ""
) (
    input  logic        clk,
    input  logic [11:0] addr,
    output logic [11:0] rgb
);

    logic [11:0] rom [0:4095];

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 12'h000;
    end

    always_ff @(posedge clk) begin
        rgb <= rom[addr];
    end

endmodule

// File: rtl/draw_rect_rom.sv
// Overlays a ROM image at a per-frame latched (xpos, ypos) onto the VGA stream
// with 3-cycle matched latency. Define DRAW_RECT_TRANSPARENT_EN for colour keying.
import vga_pkg::*;

module draw_rect_rom #(
    parameter int RECT_W = 48,
    parameter int RECT_H = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [11:0] pixel_addr,
    input  logic [11:0] rgb_pixel,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    logic [11:0] xl_q, yl_q, xl_d, yl_d;
    vga_tim_t    tim_in, tim1_q, tim2_q, tim3_q;
    logic [11:0] rgb1_q, rgb2_q, rgb3_q, rgb3_d;
    logic        inside1_q, inside2_q, inside_d;
    logic [11:0] addr_q, addr_d;
    logic [11:0] dx, dy;
    logic [12:0] h13, v13, xs13, ys13, xe13, ye13;
    logic        key_hit;

    assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                      vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in};

    always_comb begin
        xl_d = xl_q;
        yl_d = yl_q;
        if (hcount_in == 11'd0 && vcount_in == 11'd0) begin
            xl_d = xpos;
            yl_d = ypos;
        end
    end

    // 13-bit bounds so a rectangle near the right/bottom edge cannot wrap.
    always_comb begin
        h13      = {2'b00, hcount_in};
        v13      = {2'b00, vcount_in};
        xs13     = {1'b0, xl_q};
        ys13     = {1'b0, yl_q};
        xe13     = xs13 + 13'(RECT_W);
        ye13     = ys13 + 13'(RECT_H);
        dx       = {1'b0, hcount_in} - xl_q;
        dy       = {1'b0, vcount_in} - yl_q;
        inside_d = (h13 >= xs13) && (h13 < xe13) && (v13 >= ys13) && (v13 < ye13);
        addr_d   = inside_d ? {dy[5:0], dx[5:0]} : 12'h000;
    end

`ifdef DRAW_RECT_TRANSPARENT_EN
    assign key_hit = (rgb_pixel == TRANSPARENT_KEY);
`else
    assign key_hit = 1'b0;
`endif

    always_comb begin
        rgb3_d = rgb2_q;
        if (tim2_q.hblnk || tim2_q.vblnk)
            rgb3_d = 12'h000;
        else if (inside2_q && !key_hit)
            rgb3_d = rgb_pixel;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xl_q      <= '0;
            yl_q      <= '0;
            tim1_q    <= '0;
            tim2_q    <= '0;
            tim3_q    <= '0;
            rgb1_q    <= '0;
            rgb2_q    <= '0;
            rgb3_q    <= '0;
            inside1_q <= 1'b0;
            inside2_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            xl_q      <= xl_d;
            yl_q      <= yl_d;
            tim1_q    <= tim_in;
            rgb1_q    <= rgb_in;
            inside1_q <= inside_d;
            addr_q    <= addr_d;
            tim2_q    <= tim1_q;
            rgb2_q    <= rgb1_q;
            inside2_q <= inside1_q;
            tim3_q    <= tim2_q;
            rgb3_q    <= rgb3_d;
        end
    end

    assign pixel_addr = addr_q;
    assign hcount_out = tim3_q.hcount;
    assign vcount_out = tim3_q.vcount;
    assign hsync_out  = tim3_q.hsync;
    assign vsync_out  = tim3_q.vsync;
    assign hblnk_out  = tim3_q.hblnk;
    assign vblnk_out  = tim3_q.vblnk;
    assign rgb_out    = rgb3_q;

endmodule

// File: tb/tb_draw_rect_rom.sv
// Directed bench for draw_rect_rom with a behavioural 1-cycle ROM model.
module tb_draw_rect_rom;

    localparam int SRC_BG = 0, SRC_ROM = 1, SRC_BLK = 2, SRC_KEY = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos, ypos;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [11:0] pixel_addr;
    logic [11:0] rgb_pixel;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;

    logic [11:0] rom [4096];
    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [10:0] h, v;
        logic        hb, vb;
        logic [11:0] rgb, xp, yp;
        bit          chk;
        logic [11:0] addr;
        int          src;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    always @(posedge clk) rgb_pixel <= rom[pixel_addr];

    draw_rect_rom #(.RECT_W(48), .RECT_H(64)) dut (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out), .rgb_out(rgb_out)
    );

    function automatic logic [11:0] rom_fn(input logic [11:0] a);
        return a ^ 12'hA5C;
    endfunction

    function automatic vec_t mk(input int h, input int v, input bit hb, input bit vb,
                                input logic [11:0] rgb, input int xp, input int yp,
                                input bit chk, input logic [11:0] addr, input int src);
        vec_t t;
        t.h = 11'(h); t.v = 11'(v); t.hb = hb; t.vb = vb; t.rgb = rgb;
        t.xp = 12'(xp); t.yp = 12'(yp); t.chk = chk; t.addr = addr; t.src = src;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic filler(input logic [11:0] xp, input logic [11:0] yp);
        hcount_in = 11'd2000; vcount_in = 11'd1000;
        hblnk_in = 1'b0; vblnk_in = 1'b1; hsync_in = 1'b0; vsync_in = 1'b1;
        rgb_in = 12'h000; xpos = xp; ypos = yp;
    endtask

    task automatic drive(input vec_t t);
        hcount_in = t.h; vcount_in = t.v; hblnk_in = t.hb; vblnk_in = t.vb;
        hsync_in = 1'b1; vsync_in = 1'b0; rgb_in = t.rgb; xpos = t.xp; ypos = t.yp;
    endtask

    task automatic apply(input vec_t t, input string name);
        logic [11:0] exp_rgb;
        drive(t);
        @(posedge clk); #1;
        if (t.chk) check({name, ".addr"}, 32'(pixel_addr), 32'(t.addr));
        filler(t.xp, t.yp);
        @(posedge clk);
        @(posedge clk); #1;
        case (t.src)
            SRC_ROM: exp_rgb = rom_fn(t.addr);
            SRC_BLK: exp_rgb = 12'h000;
`ifdef DRAW_RECT_TRANSPARENT_EN
            SRC_KEY: exp_rgb = t.rgb;
`else
            SRC_KEY: exp_rgb = 12'hF0F;
`endif
            default: exp_rgb = t.rgb;
        endcase
        if (t.chk) begin
            check({name, ".rgb"}, 32'(rgb_out), 32'(exp_rgb));
            check({name, ".tim"},
                  32'({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}),
                  32'({t.h, t.v, 1'b1, 1'b0, t.hb, t.vb}));
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = rom_fn(12'(i));

        // After reset xl=yl=0; first frame start latches 100.
        tbl.push_back(mk(5, 5, 0, 0, 12'h111, 100, 0, 1, 12'h145, SRC_ROM));
        tbl.push_back(mk(47, 63, 0, 0, 12'h112, 100, 0, 1, 12'hFEF, SRC_ROM));
        tbl.push_back(mk(48, 0, 0, 0, 12'h222, 100, 0, 1, 12'h000, SRC_BG));
        tbl.push_back(mk(0, 0, 0, 0, 12'h000, 100, 0, 0, 12'h000, SRC_BG));
        tbl.push_back(mk(100, 0, 0, 0, 12'h333, 100, 0, 1, 12'h000, SRC_ROM));
        tbl.push_back(mk(147, 63, 0, 0, 12'h334, 100, 0, 1, 12'hFEF, SRC_ROM));
        tbl.push_back(mk(148, 0, 0, 0, 12'h444, 100, 0, 1, 12'h000, SRC_BG));
        tbl.push_back(mk(99, 10, 0, 0, 12'h555, 100, 0, 1, 12'h000, SRC_BG));
        tbl.push_back(mk(120, 64, 0, 0, 12'h666, 100, 0, 1, 12'h000, SRC_BG));
        tbl.push_back(mk(101, 1, 0, 0, 12'h667, 100, 0, 1, 12'h041, SRC_ROM));
        tbl.push_back(mk(110, 5, 1, 0, 12'h777, 100, 0, 1, 12'h14A, SRC_BLK));
        tbl.push_back(mk(130, 20, 0, 1, 12'h778, 100, 0, 1, 12'h51E, SRC_BLK));
        // xpos moves to 200 mid-frame: still drawn at 100 until next frame.
        tbl.push_back(mk(100, 10, 0, 0, 12'h779, 200, 0, 1, 12'h280, SRC_ROM));
        tbl.push_back(mk(200, 10, 0, 0, 12'h888, 200, 0, 1, 12'h000, SRC_BG));
        tbl.push_back(mk(0, 0, 0, 0, 12'h000, 200, 0, 0, 12'h000, SRC_BG));
        tbl.push_back(mk(200, 10, 0, 0, 12'h889, 200, 0, 1, 12'h280, SRC_ROM));
        tbl.push_back(mk(100, 10, 0, 0, 12'h999, 200, 0, 1, 12'h000, SRC_BG));
        // Right-edge clipping, no wrap to column 0.
        tbl.push_back(mk(0, 0, 0, 0, 12'h000, 1000, 0, 0, 12'h000, SRC_BG));
        tbl.push_back(mk(1023, 0, 0, 0, 12'h99A, 1000, 0, 1, 12'h017, SRC_ROM));
        tbl.push_back(mk(1000, 63, 0, 0, 12'h99B, 1000, 0, 1, 12'hFC0, SRC_ROM));
        tbl.push_back(mk(5, 2, 0, 0, 12'hABC, 1000, 0, 1, 12'h000, SRC_BG));
        // xl + RECT_W exceeds 11 bits.
        tbl.push_back(mk(0, 0, 0, 0, 12'h000, 2040, 0, 0, 12'h000, SRC_BG));
        tbl.push_back(mk(2045, 0, 0, 0, 12'hABD, 2040, 0, 1, 12'h005, SRC_ROM));
        tbl.push_back(mk(7, 0, 0, 0, 12'hBCD, 2040, 0, 1, 12'h000, SRC_BG));

        rst = 1'b1;
        filler(12'd0, 12'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'({pixel_addr, rgb_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
        check("reset_cnt", 32'({hcount_out, vcount_out}), 32'd0);
        rst = 1'b0;

        // Fill the pipeline with non-zero state, then reset mid-frame.
        drive(mk(0, 0, 0, 0, 12'h000, 100, 0, 0, 12'h000, SRC_BG));
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            drive(mk(100 + i, 3, 0, 0, 12'h321, 100, 0, 0, 12'h000, SRC_BG));
            @(posedge clk); #1;
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("midreset_out",
                  32'({pixel_addr, rgb_out, hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
            check("midreset_cnt", 32'({hcount_out, vcount_out}), 32'd0);
        end
        rst = 1'b0;

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // hblnk latency: must appear at exactly +3, not +2 or +4.
        drive(mk(2045, 0, 1, 0, 12'h5A5, 2040, 0, 1, 12'h005, SRC_BLK));
        @(posedge clk); #1;
        filler(12'd2040, 12'd0);
        @(posedge clk); #1;
        check("hblnk_lat2", 32'(hblnk_out), 32'd0);
        @(posedge clk); #1;
        check("hblnk_lat3", 32'(hblnk_out), 32'd1);
        check("hblnk_rgb", 32'(rgb_out), 32'd0);
        @(posedge clk); #1;
        check("hblnk_lat4", 32'(hblnk_out), 32'd0);

        // Key colour at the rectangle origin.
        rom[0] = 12'hF0F;
        apply(mk(0, 0, 0, 0, 12'h000, 100, 0, 0, 12'h000, SRC_BG), "key_fs");
        apply(mk(100, 0, 0, 0, 12'h3C3, 100, 0, 1, 12'h000, SRC_KEY), "key");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
